// File: rtl/arrow_sequencer_pkg.sv
// Shared game definitions: top-level state codes, arrow codes, button bit order
// and the judge FSM state type used by the arrow sequencer.
package game_defs;

    localparam int STATE_BITS      = 2;
    localparam int NUM_ARROWS_BITS = 2;

    localparam logic [STATE_BITS:0] STATE_IDLE  = 3'd0;
    localparam logic [STATE_BITS:0] STATE_GAME  = 3'd1;
    localparam logic [STATE_BITS:0] STATE_PAUSE = 3'd2;
    localparam logic [STATE_BITS:0] STATE_OVER  = 3'd3;

    typedef logic [NUM_ARROWS_BITS:0] arrow_t;

    localparam arrow_t ARROW_NONE  = 3'd0;
    localparam arrow_t ARROW_UP    = 3'd1;
    localparam arrow_t ARROW_DOWN  = 3'd2;
    localparam arrow_t ARROW_LEFT  = 3'd3;
    localparam arrow_t ARROW_RIGHT = 3'd4;

    // Button vector bit positions: {right, left, down, up}
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        JUDGE_WAIT = 2'd0,
        JUDGE_HIT  = 2'd1,
        JUDGE_MISS = 2'd2
    } judge_e;

    // One-hot button pattern that correctly answers a given arrow; zero for NONE
    function automatic logic [3:0] arrow_to_btn(input arrow_t arrow);
        logic [3:0] pattern;
        pattern = 4'b0000;
        case (arrow)
            ARROW_UP:    pattern[BTN_UP]    = 1'b1;
            ARROW_DOWN:  pattern[BTN_DOWN]  = 1'b1;
            ARROW_LEFT:  pattern[BTN_LEFT]  = 1'b1;
            ARROW_RIGHT: pattern[BTN_RIGHT] = 1'b1;
            default:     pattern = 4'b0000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/arrow_sequencer_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that feeds arrow generation.
// Shifts right; the feedback bit enters at the MSB.
module arrow_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic        feedback;

    assign feedback = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];
    assign state_o  = state_q;

    // Load the seed on reset, otherwise advance one step per enable
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed_i;
        end else if (step_i) begin
            state_q <= {feedback, state_q[15:1]};
        end
    end

endmodule

// File: rtl/arrow_sequencer.sv
// Arrow queue, beat judge, combo and lives tracking for the rhythm game.
// Each synchronised metronome beat shifts the queue and settles one verdict.
module arrow_sequencer
    import game_defs::*;
#(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [2:0]  LIVES_INIT = 3'd5,
    parameter logic [9:0]  COMBO_MAX  = 10'd999
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     metronome_clk,
    input  logic [STATE_BITS:0]      state,
    input  logic [3:0]               btn,
    output logic [NUM_ARROWS_BITS:0] cur_arrow0,
    output logic [NUM_ARROWS_BITS:0] cur_arrow1,
    output logic [NUM_ARROWS_BITS:0] cur_arrow2,
    output logic [NUM_ARROWS_BITS:0] cur_arrow3,
    output logic [2:0]               lives,
    output logic [9:0]               combo,
    output logic                     game_over
);

    logic [2:0]  sync_q;
    logic        sync_prev_q;
    logic        tick_q;

    arrow_t      arrow_q [4];
    logic [2:0]  lives_q;
    logic [2:0]  lives_d;
    logic [9:0]  combo_q;
    logic [9:0]  combo_d;
    logic        game_over_q;
    logic        game_over_d;
    judge_e      judge_q;

    logic        active;
    logic        press_valid;
    judge_e      press_verdict;
    judge_e      verdict_now;
    arrow_t      gen_arrow;
    logic [15:0] lfsr_state;
    logic        unused_lfsr_bits;

    assign active        = (state == STATE_GAME) && !game_over_q;
    assign press_valid   = (btn != 4'b0000) && (arrow_q[3] != ARROW_NONE) && (judge_q == JUDGE_WAIT);
    assign press_verdict = (btn == arrow_to_btn(arrow_q[3])) ? JUDGE_HIT : JUDGE_MISS;
    assign verdict_now   = press_valid ? press_verdict : judge_q;
    assign gen_arrow     = lfsr_state[2] ? ARROW_NONE : ARROW_UP + {1'b0, lfsr_state[1:0]};

    assign unused_lfsr_bits = ^lfsr_state[15:3];

    arrow_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed_i  (LFSR_SEED),
        .step_i  (active && tick_q),
        .state_o (lfsr_state)
    );

    // Bring the metronome into the clk domain and emit a one-cycle tick on its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 3'b000;
            sync_prev_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], metronome_clk};
            sync_prev_q <= sync_q[2];
            tick_q      <= sync_q[2] && !sync_prev_q;
        end
    end

    // Score the beat that is ending; an empty target arrow leaves the score alone
    always_comb begin
        lives_d     = lives_q;
        combo_d     = combo_q;
        game_over_d = game_over_q;
        if (arrow_q[3] != ARROW_NONE) begin
            if (verdict_now == JUDGE_HIT) begin
                combo_d = (combo_q >= COMBO_MAX) ? COMBO_MAX : combo_q + 10'd1;
            end else begin
                lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                combo_d = 10'd0;
                if (lives_d == 3'd0) begin
                    game_over_d = 1'b1;
                end
            end
        end
    end

    // Judge FSM plus queue and score registers; everything freezes when inactive
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                arrow_q[i] <= ARROW_NONE;
            end
            lives_q     <= LIVES_INIT;
            combo_q     <= 10'd0;
            game_over_q <= 1'b0;
            judge_q     <= JUDGE_WAIT;
        end else if (active) begin
            if (tick_q) begin
                lives_q     <= lives_d;
                combo_q     <= combo_d;
                game_over_q <= game_over_d;
                arrow_q[3]  <= arrow_q[2];
                arrow_q[2]  <= arrow_q[1];
                arrow_q[1]  <= arrow_q[0];
                arrow_q[0]  <= gen_arrow;
                judge_q     <= JUDGE_WAIT;
            end else if (press_valid) begin
                judge_q <= press_verdict;
            end
        end
    end

    assign cur_arrow0 = arrow_q[0];
    assign cur_arrow1 = arrow_q[1];
    assign cur_arrow2 = arrow_q[2];
    assign cur_arrow3 = arrow_q[3];
    assign lives      = lives_q;
    assign combo      = combo_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_arrow_sequencer.sv
// Self-checking bench for arrow_sequencer against a queue/score reference model.
module tb_arrow_sequencer;
    import game_defs::*;

    localparam logic [15:0] TAP_MASK = 16'h002D;

    logic       clk;
    logic       rst;
    logic       metronome_clk;
    logic [2:0] state;
    logic [3:0] btn;
    logic [2:0] cur_arrow0;
    logic [2:0] cur_arrow1;
    logic [2:0] cur_arrow2;
    logic [2:0] cur_arrow3;
    logic [2:0] lives;
    logic [9:0] combo;
    logic       game_over;

    int checkCount = 0;
    int failCount  = 0;

    logic [2:0]  mArrow [4];
    int          mLives;
    int          mCombo;
    bit          mOver;
    bit          mGame;
    logic [15:0] mLfsr;
    int          mVerdict;

    arrow_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .metronome_clk (metronome_clk),
        .state         (state),
        .btn           (btn),
        .cur_arrow0    (cur_arrow0),
        .cur_arrow1    (cur_arrow1),
        .cur_arrow2    (cur_arrow2),
        .cur_arrow3    (cur_arrow3),
        .lives         (lives),
        .combo         (combo),
        .game_over     (game_over)
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] dutVec();
        return {cur_arrow3, cur_arrow2, cur_arrow1, cur_arrow0, lives, combo, game_over};
    endfunction

    function automatic logic [25:0] modelVec();
        return {mArrow[3], mArrow[2], mArrow[1], mArrow[0], 3'(mLives), 10'(mCombo), mOver};
    endfunction

    function automatic logic [3:0] correctBtn(input logic [2:0] arrow);
        if (arrow == 3'd0) return 4'b0000;
        return 4'b0001 << (arrow - 3'd1);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mArrow[i] = 3'd0;
        mLives   = 5;
        mCombo   = 0;
        mOver    = 1'b0;
        mLfsr    = 16'hACE1;
        mVerdict = 0;
    endtask

    task automatic modelPress(input logic [3:0] b);
        if (mGame && !mOver && mVerdict == 0 && b != 4'b0000 && mArrow[3] != 3'd0)
            mVerdict = (b == correctBtn(mArrow[3])) ? 1 : 2;
    endtask

    task automatic modelTick();
        if (mGame && !mOver) begin
            if (mArrow[3] != 3'd0) begin
                if (mVerdict == 1) begin
                    mCombo = (mCombo >= 999) ? 999 : mCombo + 1;
                end else begin
                    mLives = (mLives == 0) ? 0 : mLives - 1;
                    mCombo = 0;
                    if (mLives == 0) mOver = 1'b1;
                end
            end
            mArrow[3] = mArrow[2];
            mArrow[2] = mArrow[1];
            mArrow[1] = mArrow[0];
            mArrow[0] = mLfsr[2] ? 3'd0 : 3'd1 + {1'b0, mLfsr[1:0]};
            mLfsr     = {^(mLfsr & TAP_MASK), mLfsr[15:1]};
            mVerdict  = 0;
        end
    endtask

    task automatic doReset();
        btn           = 4'b0000;
        metronome_clk = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pressBtn(input logic [3:0] b);
        btn = b;
        modelPress(b);
        @(posedge clk);
        #1;
        btn = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    // One metronome beat; tickBtn is driven in the cycle the tick pulse is high
    task automatic beat(input logic [3:0] tickBtn, input string tag);
        metronome_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkCount++;
        if (dutVec() !== modelVec()) begin
            failCount++;
            $display("[TB] FAIL %s-midbeat: got %h expected %h", tag, dutVec(), modelVec());
        end
        btn = tickBtn;
        modelPress(tickBtn);
        @(posedge clk);
        #1;
        btn = 4'b0000;
        modelTick();
        checkCount++;
        if (dutVec() !== modelVec()) begin
            failCount++;
            $display("[TB] FAIL %s-beat: got %h expected %h", tag, dutVec(), modelVec());
        end
        metronome_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic advanceToArrow(input string tag);
        for (int i = 0; i < 40 && mArrow[3] == 3'd0; i++) beat(4'b0000, tag);
        checkCount++;
        if (mArrow[3] == 3'd0 || cur_arrow3 === 3'd0) begin
            failCount++;
            $display("[TB] FAIL %s-reach: got arrow3 %0d expected non-NONE", tag, cur_arrow3);
        end
    endtask

    task automatic test_reset();
        doReset();
        checkCount++;
        if (dutVec() !== {3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 10'd0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reset: got %h expected %h", dutVec(), {12'd0, 3'd5, 10'd0, 1'b0});
        end
    endtask

    task automatic test_idle_ticks();
        for (int i = 0; i < 4; i++) beat(4'b0000, "idle");
        checkCount++;
        if (lives !== 3'd5 || combo !== 10'd0) begin
            failCount++;
            $display("[TB] FAIL idle-score: got lives %0d combo %0d expected 5 0", lives, combo);
        end
    endtask

    task automatic test_hit();
        int prevCombo;
        doReset();
        advanceToArrow("hit");
        prevCombo = mCombo;
        pressBtn(correctBtn(mArrow[3]));
        beat(4'b0000, "hit");
        checkCount++;
        if (combo !== 10'(prevCombo + 1) || lives !== 3'd5) begin
            failCount++;
            $display("[TB] FAIL hit-score: got combo %0d lives %0d expected %0d 5", combo, lives, prevCombo + 1);
        end
    endtask

    task automatic test_miss_then_correct();
        logic [3:0] good;
        doReset();
        advanceToArrow("miss");
        good = correctBtn(mArrow[3]);
        pressBtn({good[2:0], good[3]});
        pressBtn(good);
        beat(4'b0000, "miss");
        checkCount++;
        if (lives !== 3'd4 || combo !== 10'd0) begin
            failCount++;
            $display("[TB] FAIL miss-score: got lives %0d combo %0d expected 4 0", lives, combo);
        end
    endtask

    task automatic test_same_cycle();
        doReset();
        advanceToArrow("same");
        beat(correctBtn(mArrow[3]), "same-hit");
        checkCount++;
        if (combo !== 10'd1) begin
            failCount++;
            $display("[TB] FAIL same-hit: got combo %0d expected 1", combo);
        end
        advanceToArrow("same2");
        beat(4'b0011, "same-multi");
        checkCount++;
        if (lives !== 3'd4 || combo !== 10'd0) begin
            failCount++;
            $display("[TB] FAIL same-multi: got lives %0d combo %0d expected 4 0", lives, combo);
        end
    endtask

    task automatic test_pause();
        logic [25:0] snap;
        doReset();
        advanceToArrow("pause");
        snap  = dutVec();
        state = STATE_PAUSE;
        mGame = 1'b0;
        pressBtn(4'b0001);
        for (int i = 0; i < 3; i++) begin
            beat(4'b0000, "pause");
            checkCount++;
            if (dutVec() !== snap) begin
                failCount++;
                $display("[TB] FAIL pause-frozen: got %h expected %h", dutVec(), snap);
            end
        end
        state = STATE_GAME;
        mGame = 1'b1;
        beat(4'b0000, "resume");
    endtask

    task automatic test_rst_mid_beat();
        doReset();
        advanceToArrow("rstmid");
        pressBtn(correctBtn(mArrow[3]));
        beat(4'b0000, "rstmid-hit");
        advanceToArrow("rstmid2");
        pressBtn(correctBtn(mArrow[3]));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        repeat (8) @(posedge clk);
        #1;
        checkCount++;
        if (dutVec() !== {12'd0, 3'd5, 10'd0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL rstmid-state: got %h expected %h", dutVec(), {12'd0, 3'd5, 10'd0, 1'b0});
        end
        beat(4'b0000, "rstmid-after");
    endtask

    task automatic test_random();
        int kind;
        logic [3:0] good;
        doReset();
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            good = correctBtn(mArrow[3]);
            if (good == 4'b0000) good = 4'b0001 << $urandom_range(0, 3);
            case (kind)
                1: begin pressBtn(good); beat(4'b0000, "rand-hit"); end
                2: begin pressBtn({good[1:0], good[3:2]}); beat(4'b0000, "rand-wrong"); end
                3: beat(good, "rand-tickhit");
                4: begin pressBtn(good | {good[2:0], good[3]}); beat(4'b0000, "rand-multi"); end
                default: beat(4'b0000, "rand-none");
            endcase
        end
    endtask

    task automatic test_game_over();
        logic [25:0] snap;
        doReset();
        for (int i = 0; i < 80 && !mOver; i++) beat(4'b0000, "over");
        checkCount++;
        if (game_over !== 1'b1 || lives !== 3'd0 || !mOver) begin
            failCount++;
            $display("[TB] FAIL over-flag: got game_over %0b lives %0d expected 1 0", game_over, lives);
        end
        snap = dutVec();
        for (int i = 0; i < 3; i++) begin
            pressBtn(4'b0001);
            beat(4'b0000, "over-frozen");
            checkCount++;
            if (dutVec() !== snap) begin
                failCount++;
                $display("[TB] FAIL over-frozen: got %h expected %h", dutVec(), snap);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        rst           = 1'b1;
        state         = STATE_GAME;
        btn           = 4'b0000;
        metronome_clk = 1'b0;
        mGame         = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        test_reset();
        test_idle_ticks();
        test_hit();
        test_miss_then_correct();
        test_same_cycle();
        test_pause();
        test_rst_mid_beat();
        test_random();
        test_game_over();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
